// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared types and defaults for the sequence-generator run controller.
//   seqgen_state_t : run controller FSM state encoding (binary)
//   STATE_W_DEF    : default generator state width
//   CNT_W_DEF      : default width of run length / step counter / y counter
package seqgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } seqgen_state_t;

  localparam int STATE_W_DEF = 3;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seqgen_tog_timer.sv
// seqgen_tog_timer: direction-toggle timer for the run controller.
//   clk, reset : clock, asynchronous active-high reset
//   step       : one generator step taken this cycle
//   clear      : restart the period (new run accepted)
//   flip       : high in the cycle whose step completes a period, so the
//                direction inverts on the same edge as that step.
//                Constant 0 when TOG_PERIOD is 0.
module seqgen_tog_timer #(
  parameter int TOG_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic clear,
  output logic flip
);

  localparam int   TW     = (TOG_PERIOD > 1) ? $clog2(TOG_PERIOD) : 1;
  localparam int   LOAD_I = (TOG_PERIOD > 0) ? TOG_PERIOD - 1 : 0;
  localparam logic EN     = (TOG_PERIOD != 0);
  localparam logic [TW-1:0] LOAD = TW'(LOAD_I);

  // Down-counter: holds the number of steps still to go before the period
  // ends; terminal count 0 with a step marks the flip.
  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (step) begin
      if (cnt == '0) cnt <= LOAD;
      else           cnt <= cnt - TW'(1);
    end
  end

  assign flip = EN && step && (cnt == '0);

endmodule

// File: rtl/seqgen_ctrl.sv
// seqgen_ctrl: run controller for the 3-bit sequence-generator datapath.
// Owns the generator state register, drives its direction input and runs it
// for a programmed number of steps, counting y assertions.
//   clk, reset       : clock, asynchronous active-high reset
//   start            : run request, accepted only in IDLE
//   len, seed, dir   : run length, initial state, initial direction (sampled on accept)
//   pause            : stall stepping while high
//   qn_in, y_in      : generator next state and output for (q_cur, x_out)
//   q_cur, x_out     : generator state and direction
//   busy, done       : handshake (busy in RUN/HOLD, one-cycle done pulse)
//   step_cnt, y_count: steps taken, steps with y_in high (saturating)
//
// state  | meaning
// S_IDLE | waiting for start; results of last run held
// S_RUN  | stepping once per cycle while pause is low
// S_HOLD | paused; all registers frozen
// S_DONE | run complete; done pulse for one cycle
module seqgen_ctrl
  import seqgen_pkg::*;
#(
  parameter int STATE_W    = STATE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TOG_PERIOD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic [STATE_W-1:0] seed,
  input  logic               dir,
  input  logic               pause,
  input  logic [STATE_W-1:0] qn_in,
  input  logic               y_in,
  output logic [STATE_W-1:0] q_cur,
  output logic               x_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [CNT_W-1:0]   y_count
);

  seqgen_state_t state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic accept, step, flip;

  assign accept = (state == S_IDLE) && start;
  assign step   = (state == S_RUN) && !pause;

  seqgen_tog_timer #(.TOG_PERIOD(TOG_PERIOD)) u_tog (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .clear (accept),
    .flip  (flip)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (pause)                        state_nxt = S_HOLD;
        else if (remaining == CNT_W'(1))  state_nxt = S_DONE;
      end
      S_HOLD: if (!pause) state_nxt = S_RUN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_HOLD);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_cur     <= '0;
      x_out     <= 1'b0;
      remaining <= '0;
      step_cnt  <= '0;
      y_count   <= '0;
    end else if (accept) begin
      q_cur     <= seed;
      x_out     <= dir;
      remaining <= len;
      step_cnt  <= '0;
      y_count   <= '0;
    end else if (step) begin
      q_cur     <= qn_in;
      remaining <= remaining - CNT_W'(1);
      step_cnt  <= step_cnt + CNT_W'(1);
      if (y_in && (y_count != '1)) y_count <= y_count + CNT_W'(1);
      if (flip) x_out <= ~x_out;
    end
  end

endmodule

// File: tb/tb_seqgen_ctrl.sv
module tb_seqgen_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start_v;
  logic [7:0] len;
  logic [2:0] seed;
  logic       dir, pause;

  // instance 0: TOG_PERIOD=0, instance 1: TOG_PERIOD=4, instance 2: CNT_W=3, TOG_PERIOD=1
  logic [2:0] q0, q1, q2, qn0, qn1, qn2;
  logic       x0, x1, x2, y0, y1, y2;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] sc0, sc1, yc0, yc1;
  logic [2:0] sc2, yc2;

  // reference generator: +1 when x=1, -1 when x=0, y asserted in state 7
  assign qn0 = x0 ? q0 + 3'd1 : q0 - 3'd1;
  assign qn1 = x1 ? q1 + 3'd1 : q1 - 3'd1;
  assign qn2 = x2 ? q2 + 3'd1 : q2 - 3'd1;
  assign y0  = (q0 == 3'd7);
  assign y1  = (q1 == 3'd7);
  assign y2  = (q2 == 3'd7);

  seqgen_ctrl #(.STATE_W(3), .CNT_W(8), .TOG_PERIOD(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .len(len), .seed(seed), .dir(dir),
    .pause(pause), .qn_in(qn0), .y_in(y0), .q_cur(q0), .x_out(x0), .busy(busy0),
    .done(done0), .step_cnt(sc0), .y_count(yc0));

  seqgen_ctrl #(.STATE_W(3), .CNT_W(8), .TOG_PERIOD(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .len(len), .seed(seed), .dir(dir),
    .pause(pause), .qn_in(qn1), .y_in(y1), .q_cur(q1), .x_out(x1), .busy(busy1),
    .done(done1), .step_cnt(sc1), .y_count(yc1));

  seqgen_ctrl #(.STATE_W(3), .CNT_W(3), .TOG_PERIOD(1)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .len(len[2:0]), .seed(seed), .dir(dir),
    .pause(pause), .qn_in(qn2), .y_in(y2), .q_cur(q2), .x_out(x2), .busy(busy2),
    .done(done2), .step_cnt(sc2), .y_count(yc2));

  typedef struct {
    int         inst;
    logic       start;
    logic [7:0] len;
    logic [2:0] seed;
    logic       dir;
    logic       pause;
    logic [2:0] q;
    logic       x;
    logic       busy;
    logic       done;
    logic [7:0] sc;
    logic [7:0] yc;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(int inst, int st, int l, int sd, int d, int p,
                              int q, int x, int b, int dn, int sc, int yc);
    vec_t v;
    v.inst = inst;       v.start = st[0];   v.len = 8'(l);   v.seed = 3'(sd);
    v.dir = d[0];        v.pause = p[0];    v.q = 3'(q);     v.x = x[0];
    v.busy = b[0];       v.done = dn[0];    v.sc = 8'(sc);   v.yc = 8'(yc);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic read_out(input int i, output logic [2:0] q, output logic x,
                          output logic b, output logic d,
                          output logic [7:0] sc, output logic [7:0] yc);
    case (i)
      0:       begin q = q0; x = x0; b = busy0; d = done0; sc = sc0; yc = yc0; end
      1:       begin q = q1; x = x1; b = busy1; d = done1; sc = sc1; yc = yc1; end
      default: begin q = q2; x = x2; b = busy2; d = done2; sc = {5'd0, sc2}; yc = {5'd0, yc2}; end
    endcase
  endtask

  task automatic chk_all(input string tag, input int i, input logic [2:0] eq, input logic ex,
                         input logic eb, input logic ed, input logic [7:0] esc,
                         input logic [7:0] eyc);
    logic [2:0] q; logic x, b, d; logic [7:0] sc, yc;
    read_out(i, q, x, b, d, sc, yc);
    chk({tag, " q_cur"}, int'(q), int'(eq));
    chk({tag, " x_out"}, int'(x), int'(ex));
    chk({tag, " busy"}, int'(b), int'(eb));
    chk({tag, " done"}, int'(d), int'(ed));
    chk({tag, " step_cnt"}, int'(sc), int'(esc));
    chk({tag, " y_count"}, int'(yc), int'(eyc));
  endtask

  initial begin
    // basic run: inst0, seed 0, dir 1, len 3
    tbl.push_back(mk(0,1,3,0,1,0, 0,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,1,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,1,0,1,3,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,1,0,0,3,0));
    // toggle: inst1, seed 5, dir 1, len 10, period 4
    tbl.push_back(mk(1,1,10,5,1,0, 5,1,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 6,1,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 7,1,1,0,2,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,1,0,3,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,0,4,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1,0,5,1));
    tbl.push_back(mk(1,0,0,0,0,0, 7,0,1,0,6,1));
    tbl.push_back(mk(1,0,0,0,0,0, 6,0,1,0,7,2));
    tbl.push_back(mk(1,0,0,0,0,0, 5,1,1,0,8,2));
    tbl.push_back(mk(1,0,0,0,0,0, 6,1,1,0,9,2));
    tbl.push_back(mk(1,0,0,0,0,0, 7,1,0,1,10,2));
    tbl.push_back(mk(1,0,0,0,0,0, 7,1,0,0,10,2));
    // pause: inst0, seed 2, dir 0, len 4, pause for 3 cycles after step 2
    tbl.push_back(mk(0,1,4,2,0,0, 2,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0, 7,0,1,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0, 6,0,0,1,4,1));
    tbl.push_back(mk(0,0,0,0,0,0, 6,0,0,0,4,1));
    // len 0: inst0, seed 6
    tbl.push_back(mk(0,1,0,6,0,0, 6,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 6,0,0,0,0,0));
    // max length on a 3-bit counter: inst2, seed 7, dir 1, len 7, period 1
    tbl.push_back(mk(2,1,7,7,1,0, 7,1,1,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0, 0,0,1,0,1,1));
    tbl.push_back(mk(2,0,0,0,0,0, 7,1,1,0,2,1));
    tbl.push_back(mk(2,0,0,0,0,0, 0,0,1,0,3,2));
    tbl.push_back(mk(2,0,0,0,0,0, 7,1,1,0,4,2));
    tbl.push_back(mk(2,0,0,0,0,0, 0,0,1,0,5,3));
    tbl.push_back(mk(2,0,0,0,0,0, 7,1,1,0,6,3));
    tbl.push_back(mk(2,0,0,0,0,0, 0,0,0,1,7,4));
    tbl.push_back(mk(2,0,0,0,0,0, 0,0,0,0,7,4));

    reset = 1'b1; start_v = '0; len = '0; seed = '0; dir = 1'b0; pause = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) chk_all($sformatf("reset inst%0d", i), i, 0, 0, 0, 0, 0, 0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      len = tbl[i].len; seed = tbl[i].seed; dir = tbl[i].dir; pause = tbl[i].pause;
      start_v = '0;
      start_v[tbl[i].inst] = tbl[i].start;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), tbl[i].inst, tbl[i].q, tbl[i].x, tbl[i].busy,
              tbl[i].done, tbl[i].sc, tbl[i].yc);
    end
    start_v = '0; pause = 1'b0;

    // ignored start during RUN, then asynchronous abort
    start_v = 3'b010; len = 8'd20; seed = 3'd3; dir = 1'b1;
    @(posedge clk); #1; start_v = '0;
    chk_all("run accept", 1, 3, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("run step1", 1, 4, 1, 1, 0, 1, 0);
    start_v = 3'b010; len = 8'd2; seed = 3'd0; dir = 1'b0;
    @(posedge clk); #1;
    chk_all("ignored start", 1, 5, 1, 1, 0, 2, 0);
    @(posedge clk); #1;
    chk_all("ignored start 2", 1, 6, 1, 1, 0, 3, 0);
    start_v = '0;
    @(posedge clk); #1;
    chk_all("run step4", 1, 7, 0, 1, 0, 4, 0);
    @(posedge clk); #1;
    chk_all("run step5 len kept", 1, 6, 0, 1, 0, 5, 1);
    #2 reset = 1'b1;
    #1;
    chk_all("async abort", 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_all($sformatf("post abort c%0d", c), 1, 0, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
